// File: rtl/disk_ucode_pkg.sv
// Shared definitions for the disk controller microcode sequencer: microword
// layout, opcode and state encodings, and the address increment helper.
package disk_ucode_pkg;

  localparam int UADDR_W = 10;
  localparam int UWORD_W = 18;
  localparam int COND_W  = 16;
  localparam int FUNC_W  = 5;

  // Microword field positions and widths
  localparam int OP_LSB  = 15;
  localparam int OP_W    = 3;
  localparam int INV_BIT = 14;
  localparam int SEL_LSB = 10;
  localparam int SEL_W   = 4;
  localparam int TGT_LSB = 0;
  localparam int TGT_W   = 10;

  typedef enum logic [OP_W-1:0] {
    OP_NEXT     = 3'd0,
    OP_JUMP     = 3'd1,
    OP_BRANCH   = 3'd2,
    OP_CALL     = 3'd3,
    OP_RETURN   = 3'd4,
    OP_WAIT     = 3'd5,
    OP_DISPATCH = 3'd6,
    OP_HALT     = 3'd7
  } op_e;

  typedef enum logic {
    ST_HALTED = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  typedef struct packed {
    op_e               op;
    logic              inv;
    logic [SEL_W-1:0]  sel;
    logic [TGT_W-1:0]  tgt;
  } uword_t;

  // The microcode address space wraps from the top entry back to zero.
  function automatic logic [UADDR_W-1:0] addr_inc(input logic [UADDR_W-1:0] a);
    return a + UADDR_W'(1);
  endfunction

endpackage

// File: rtl/disk_ucode_stack.sv
// Return-address LIFO for microcode CALL/RETURN. The stack pointer counts
// occupied entries; the top of stack is always the entry just below it.
module disk_ucode_stack
  import disk_ucode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr,
  input  logic               push,
  input  logic               pop,
  input  logic [UADDR_W-1:0] din,
  output logic [UADDR_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]   sp_q;
  logic [PTR_W-1:0]   top;
  logic [UADDR_W-1:0] mem_q [2**PTR_W];

  assign top   = sp_q - PTR_W'(1);
  assign full  = (sp_q == PTR_W'(DEPTH));
  assign empty = (sp_q == '0);
  assign dout  = mem_q[top];

  // Stack pointer: clear wins, overflow and underflow requests are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q <= '0;
    end else if (clr) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + PTR_W'(1);
    end else if (pop && !empty) begin
      sp_q <= top;
    end
  end

  // Entry storage needs no reset; only entries below the pointer are ever read.
  always_ff @(posedge clk_i) begin
    if (push && !full && !clr) begin
      mem_q[sp_q] <= din;
    end
  end

endmodule

// File: rtl/disk_ucode_sequencer.sv
// Microprogram sequencer for the disk controller microcode ROM. While running,
// dat_i holds the word at pc and adr_o presents the next address so the ROM
// register delivers the following word without a bubble.
module disk_ucode_sequencer
  import disk_ucode_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int DISP_W      = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic [UADDR_W-1:0] adr_o,
  input  logic [UWORD_W-1:0] dat_i,
  input  logic               start_i,
  input  logic [UADDR_W-1:0] start_addr_i,
  input  logic               abort_i,
  input  logic [COND_W-1:0]  cond_i,
  input  logic [DISP_W-1:0]  dispatch_i,
  output logic [FUNC_W-1:0]  func_o,
  output logic               func_stb_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  state_e             state_q;
  logic [UADDR_W-1:0] pc_q;
  logic               done_q;
  logic               err_q;

  uword_t             uw;
  logic               running;
  logic               cond;
  logic [UADDR_W-1:0] pc_inc;
  logic [UADDR_W-1:0] disp_adr;
  logic [UADDR_W-1:0] next_pc;
  logic               halt_req;
  logic               fault;
  logic               push_req;
  logic               pop_req;
  logic               stay_run;

  logic               stk_clr;
  logic               stk_push;
  logic               stk_pop;
  logic [UADDR_W-1:0] stack_dout;
  logic               stack_full;
  logic               stack_empty;

  assign uw       = uword_t'(dat_i);
  assign running  = (state_q == ST_RUN);
  assign cond     = cond_i[uw.sel] ^ uw.inv;
  assign pc_inc   = addr_inc(pc_q);
  assign disp_adr = {uw.tgt[UADDR_W-1:DISP_W], dispatch_i};

  // Decode the executing microword into a next address and control requests.
  always_comb begin
    next_pc  = pc_inc;
    halt_req = 1'b0;
    fault    = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    case (uw.op)
      OP_NEXT:     next_pc = pc_inc;
      OP_JUMP:     next_pc = uw.tgt;
      OP_BRANCH:   if (cond) next_pc = uw.tgt;
      OP_CALL: begin
        if (stack_full) begin
          fault = 1'b1;
        end else begin
          push_req = 1'b1;
          next_pc  = uw.tgt;
        end
      end
      OP_RETURN: begin
        if (stack_empty) begin
          fault = 1'b1;
        end else begin
          pop_req = 1'b1;
          next_pc = stack_dout;
        end
      end
      OP_WAIT:     if (!cond) next_pc = pc_q;
      OP_DISPATCH: next_pc = disp_adr;
      OP_HALT:     halt_req = 1'b1;
      default:     next_pc = pc_inc;
    endcase
  end

  // Any cycle that ends in HALTED presents the entry address, so a following
  // start finds the correct word already latched in the ROM.
  assign stay_run = running && !abort_i && !halt_req && !fault;
  assign adr_o    = stay_run ? next_pc : start_addr_i;

  assign stk_clr  = abort_i || (!running && start_i);
  assign stk_push = running && push_req && !abort_i;
  assign stk_pop  = running && pop_req && !abort_i;

  assign func_stb_o = running && (uw.op == OP_NEXT);
  assign func_o     = func_stb_o ? {uw.inv, uw.sel} : '0;
  assign busy_o     = running;
  assign done_o     = done_q;
  assign err_o      = err_q;

  disk_ucode_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (stk_clr),
    .push   (stk_push),
    .pop    (stk_pop),
    .din    (pc_inc),
    .dout   (stack_dout),
    .full   (stack_full),
    .empty  (stack_empty)
  );

  // Sequencer state, program counter and the registered done/error flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_HALTED;
      pc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_HALTED: begin
          if (start_i && !abort_i) begin
            state_q <= ST_RUN;
            pc_q    <= start_addr_i;
            err_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state_q <= ST_HALTED;
          end else if (fault) begin
            state_q <= ST_HALTED;
            err_q   <= 1'b1;
          end else if (halt_req) begin
            state_q <= ST_HALTED;
            done_q  <= 1'b1;
          end else begin
            pc_q <= next_pc;
          end
        end
        default: state_q <= ST_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_disk_ucode_sequencer.sv
// Scoreboard bench for disk_ucode_sequencer with a registered ROM model.
// Directed programs push their hand-derived per-cycle traces into a queue;
// a negedge monitor pops and compares whenever the sequencer is busy or
// pulses done.
module tb_disk_ucode_sequencer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  adr_o;
  logic [17:0] rom_q;
  logic        start_i;
  logic [9:0]  start_addr_i;
  logic        abort_i;
  logic [15:0] cond_i;
  logic [3:0]  dispatch_i;
  logic [4:0]  func_o;
  logic        func_stb_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [9:0] adr;
    logic       stb;
    logic [4:0] func;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_act;
  obs_t mon_exp;

  logic [17:0] rom [1024];

  disk_ucode_sequencer #(
    .STACK_DEPTH (4),
    .DISP_W      (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .adr_o        (adr_o),
    .dat_i        (rom_q),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .abort_i      (abort_i),
    .cond_i       (cond_i),
    .dispatch_i   (dispatch_i),
    .func_o       (func_o),
    .func_stb_o   (func_stb_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: one-cycle registered read of the presented address.
  always @(posedge clk) rom_q <= rom[adr_o];

  // Monitor: every busy or done cycle must match the next expected observation.
  always @(negedge clk) begin
    if (rst_n && (busy_o || done_o)) begin
      mon_act.busy = busy_o;
      mon_act.done = done_o;
      mon_act.adr  = adr_o;
      mon_act.stb  = func_stb_o;
      mon_act.func = func_o;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_output actual=%h required=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("[TB] FAIL scoreboard actual=%h required=%h (busy,done,adr,stb,func)",
                   mon_act, mon_exp);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [17:0] enc(input logic [2:0] op, input logic inv,
                                      input logic [3:0] sel, input logic [9:0] tgt);
    return {op, inv, sel, tgt};
  endfunction

  task automatic push_run(input logic [9:0] adr, input logic stb, input logic [4:0] func);
    obs_t o;
    o.busy = 1'b1; o.done = 1'b0; o.adr = adr; o.stb = stb; o.func = func;
    exp_q.push_back(o);
  endtask

  task automatic push_done(input logic [9:0] adr);
    obs_t o;
    o.busy = 1'b0; o.done = 1'b1; o.adr = adr; o.stb = 1'b0; o.func = 5'h00;
    exp_q.push_back(o);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [9:0] addr);
    @(posedge clk);
    #1;
    start_addr_i = addr;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Bounded wait for the run to end, then one more cycle for any done pulse.
  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        idle = 1'b1;
        break;
      end
    end
    check_output({name, "_idle"}, {31'd0, idle}, 32'd1);
    @(negedge clk);
    check_output({name, "_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    start_addr_i = 10'h123;
    abort_i      = 1'b0;
    cond_i       = 16'h0000;
    dispatch_i   = 4'h0;

    for (int i = 0; i < 1024; i++) rom[i] = enc(3'd7, 1'b0, 4'h0, 10'h000);
    rom[10'h010] = enc(3'd0, 1'b1, 4'h5, 10'h000);
    rom[10'h011] = enc(3'd0, 1'b0, 4'hA, 10'h000);
    rom[10'h020] = enc(3'd2, 1'b0, 4'h3, 10'h200);
    rom[10'h030] = enc(3'd2, 1'b1, 4'h3, 10'h200);
    rom[10'h040] = enc(3'd3, 1'b0, 4'h0, 10'h300);
    rom[10'h300] = enc(3'd4, 1'b0, 4'h0, 10'h000);
    rom[10'h060] = enc(3'd3, 1'b0, 4'h0, 10'h070);
    rom[10'h070] = enc(3'd3, 1'b0, 4'h0, 10'h080);
    rom[10'h080] = enc(3'd3, 1'b0, 4'h0, 10'h090);
    rom[10'h090] = enc(3'd3, 1'b0, 4'h0, 10'h0A0);
    rom[10'h0A0] = enc(3'd3, 1'b0, 4'h0, 10'h0B0);
    rom[10'h0C0] = enc(3'd4, 1'b0, 4'h0, 10'h000);
    rom[10'h050] = enc(3'd5, 1'b0, 4'h7, 10'h000);
    rom[10'h0D0] = enc(3'd3, 1'b0, 4'h0, 10'h050);
    rom[10'h3FF] = enc(3'd0, 1'b0, 4'h3, 10'h000);
    rom[10'h0E0] = enc(3'd6, 1'b0, 4'h0, 10'h1A0);
    rom[10'h0F0] = enc(3'd0, 1'b0, 4'h1, 10'h000);
    rom[10'h0F1] = enc(3'd0, 1'b1, 4'hF, 10'h000);
    rom[10'h0F2] = enc(3'd1, 1'b0, 4'h0, 10'h0F0);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("reset_busy", {31'd0, busy_o}, 32'd0);
    check_output("reset_stb", {31'd0, func_stb_o}, 32'd0);
    check_output("reset_func", {27'd0, func_o}, 32'd0);
    check_output("reset_done", {31'd0, done_o}, 32'd0);
    check_output("reset_err", {31'd0, err_o}, 32'd0);
    check_output("reset_adr", {22'd0, adr_o}, 32'h123);
    check_output("reset_pc", {22'd0, dut.pc_q}, 32'd0);

    // NEXT, NEXT, HALT
    push_run(10'h011, 1'b1, 5'h15);
    push_run(10'h012, 1'b1, 5'h0A);
    push_run(10'h010, 1'b0, 5'h00);
    push_done(10'h010);
    apply_stimulus(10'h010);
    wait_idle("next_halt");

    // BRANCH taken / not taken, plain and inverted
    cond_i = 16'h0008;
    push_run(10'h200, 1'b0, 5'h00); push_run(10'h020, 1'b0, 5'h00); push_done(10'h020);
    apply_stimulus(10'h020);
    wait_idle("branch_taken");
    cond_i = 16'h0000;
    push_run(10'h021, 1'b0, 5'h00); push_run(10'h020, 1'b0, 5'h00); push_done(10'h020);
    apply_stimulus(10'h020);
    wait_idle("branch_not_taken");
    cond_i = 16'h0008;
    push_run(10'h031, 1'b0, 5'h00); push_run(10'h030, 1'b0, 5'h00); push_done(10'h030);
    apply_stimulus(10'h030);
    wait_idle("branch_inv_set");
    cond_i = 16'h0000;
    push_run(10'h200, 1'b0, 5'h00); push_run(10'h030, 1'b0, 5'h00); push_done(10'h030);
    apply_stimulus(10'h030);
    wait_idle("branch_inv_clear");

    // CALL / RETURN
    push_run(10'h300, 1'b0, 5'h00); push_run(10'h041, 1'b0, 5'h00);
    push_run(10'h040, 1'b0, 5'h00); push_done(10'h040);
    apply_stimulus(10'h040);
    wait_idle("call_return");

    // Five nested CALLs overflow a four-entry stack
    push_run(10'h070, 1'b0, 5'h00); push_run(10'h080, 1'b0, 5'h00);
    push_run(10'h090, 1'b0, 5'h00); push_run(10'h0A0, 1'b0, 5'h00);
    push_run(10'h060, 1'b0, 5'h00);
    apply_stimulus(10'h060);
    wait_idle("call_overflow");
    check_output("overflow_err", {31'd0, err_o}, 32'd1);

    // A new start clears the error and the stack
    push_run(10'h011, 1'b1, 5'h15); push_run(10'h012, 1'b1, 5'h0A);
    push_run(10'h010, 1'b0, 5'h00); push_done(10'h010);
    apply_stimulus(10'h010);
    check_output("start_clears_err", {31'd0, err_o}, 32'd0);
    wait_idle("restart");

    // RETURN on an empty stack
    push_run(10'h0C0, 1'b0, 5'h00);
    apply_stimulus(10'h0C0);
    wait_idle("return_underflow");
    check_output("underflow_err", {31'd0, err_o}, 32'd1);

    // WAIT holds for six cycles; a start pulse while running is ignored
    cond_i = 16'h0000;
    for (int i = 0; i < 6; i++) push_run(10'h050, 1'b0, 5'h00);
    push_run(10'h051, 1'b0, 5'h00); push_run(10'h050, 1'b0, 5'h00); push_done(10'h050);
    apply_stimulus(10'h050);
    repeat (2) @(posedge clk);
    #1 start_i = 1'b1; start_addr_i = 10'h010;
    @(posedge clk);
    #1 start_i = 1'b0; start_addr_i = 10'h050;
    repeat (3) @(posedge clk);
    #1 cond_i[7] = 1'b1;
    wait_idle("wait_release");
    check_output("wait_start_clears_err", {31'd0, err_o}, 32'd0);
    cond_i = 16'h0000;

    // Abort inside a WAIT reached through a CALL
    push_run(10'h050, 1'b0, 5'h00); push_run(10'h050, 1'b0, 5'h00);
    push_run(10'h050, 1'b0, 5'h00); push_run(10'h0D0, 1'b0, 5'h00);
    apply_stimulus(10'h0D0);
    repeat (3) @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    check_output("abort_busy", {31'd0, busy_o}, 32'd0);
    check_output("abort_stack_empty", {31'd0, dut.stack_empty}, 32'd1);
    wait_idle("abort_wait");
    check_output("abort_no_err", {31'd0, err_o}, 32'd0);

    // NEXT at the top address wraps to zero
    push_run(10'h000, 1'b1, 5'h03); push_run(10'h3FF, 1'b0, 5'h00); push_done(10'h3FF);
    apply_stimulus(10'h3FF);
    wait_idle("pc_wrap");

    // DISPATCH replaces the low target bits
    dispatch_i = 4'h5;
    push_run(10'h1A5, 1'b0, 5'h00); push_run(10'h0E0, 1'b0, 5'h00); push_done(10'h0E0);
    apply_stimulus(10'h0E0);
    wait_idle("dispatch");
    dispatch_i = 4'h0;

    // Reset in the middle of a NEXT loop
    push_run(10'h0F1, 1'b1, 5'h01); push_run(10'h0F2, 1'b1, 5'h1F);
    apply_stimulus(10'h0F0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_output("midreset_busy", {31'd0, busy_o}, 32'd0);
    check_output("midreset_stb", {31'd0, func_stb_o}, 32'd0);
    check_output("midreset_func", {27'd0, func_o}, 32'd0);
    check_output("midreset_pc", {22'd0, dut.pc_q}, 32'd0);
    check_output("midreset_adr", {22'd0, adr_o}, 32'h0F0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("midreset_drained", exp_q.size(), 32'd0);
    exp_q.delete();

    // start_i together with abort_i while halted stays halted
    @(posedge clk);
    #1 start_i = 1'b1; abort_i = 1'b1; start_addr_i = 10'h010;
    @(posedge clk);
    #1 start_i = 1'b0; abort_i = 1'b0;
    check_output("start_abort_busy", {31'd0, busy_o}, 32'd0);
    repeat (3) @(negedge clk);
    check_output("start_abort_quiet", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
